// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises I-cache and D-cache line transactions
// onto one fixed-latency RAM port, alternating grants when both requesters contend.
module mem_arbiter #(
   parameter int unsigned MEM_LATENCY = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ic_req,
   input  logic [19:0]  ic_addr,
   output logic         ic_ready,
   output logic [127:0] ic_data,
   input  logic         dc_req,
   input  logic         dc_we,
   input  logic [19:0]  dc_addr,
   input  logic [127:0] dc_wdata,
   output logic         dc_ready,
   output logic [127:0] dc_data,
   output logic [19:0]  mem_rd_addr,
   input  logic [127:0] mem_rdata,
   output logic [19:0]  mem_wr_addr,
   output logic [127:0] mem_wdata,
   output logic         mem_we
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 128;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                last_grant_q;
   logic                src_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   ic_data_q;
   logic [DATA_W-1:0]   dc_data_q;
   logic                ic_ready_q;
   logic                dc_ready_q;
   logic                mem_we_q;

   logic                grant_any_c;
   logic                grant_dc_c;

   // On a tie the source that was not served last wins.
   assign grant_any_c = ic_req | dc_req;
   assign grant_dc_c  = dc_req & (~ic_req | ~last_grant_q);

   // Arbitration, latency count and response sequencing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         src_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ic_data_q    <= '0;
         dc_data_q    <= '0;
         ic_ready_q   <= 1'b0;
         dc_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         ic_ready_q <= 1'b0;
         dc_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_any_c) begin
                  src_q        <= grant_dc_c;
                  last_grant_q <= grant_dc_c;
                  addr_q       <= grant_dc_c ? dc_addr : ic_addr;
                  wdata_q      <= grant_dc_c ? dc_wdata : '0;
                  we_q         <= grant_dc_c & dc_we;
                  cnt_q        <= CNT_INIT;
                  // A one-cycle latency puts the write strobe in the first BUSY cycle.
                  mem_we_q     <= (CNT_INIT == '0) & grant_dc_c & dc_we;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  if (!we_q) begin
                     if (src_q) dc_data_q <= mem_rdata;
                     else       ic_data_q <= mem_rdata;
                  end
                  ic_ready_q <= ~src_q;
                  dc_ready_q <= src_q;
                  state_q    <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) mem_we_q <= we_q;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ic_ready    = ic_ready_q;
   assign ic_data     = ic_data_q;
   assign dc_ready    = dc_ready_q;
   assign dc_data     = dc_data_q;
   assign mem_rd_addr = addr_q;
   assign mem_wr_addr = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-5 instance driven through reads,
// writes, contention and reset aborts, plus a latency-1 instance for back-to-back timing.
module tb_mem_arbiter;

   localparam int unsigned LAT = 5;

   typedef struct packed {
      logic         src;
      logic [127:0] data;
   } resp_t;

   typedef struct packed {
      logic [19:0]  addr;
      logic [127:0] data;
   } wr_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         ic_req, dc_req, dc_we, ic_ready, dc_ready, mem_we;
   logic [19:0]  ic_addr, dc_addr, mem_rd_addr, mem_wr_addr;
   logic [127:0] dc_wdata, ic_data, dc_data, mem_rdata, mem_wdata;

   logic         ic_req1, dc_req1, dc_we1, ic_ready1, dc_ready1, mem_we1;
   logic [19:0]  ic_addr1, dc_addr1, mem_rd_addr1, mem_wr_addr1;
   logic [127:0] dc_wdata1, ic_data1, dc_data1, mem_rdata1, mem_wdata1;

   int           nchecks = 0;
   int           nerrors = 0;
   int           cyc = 0;
   int           we_cnt = 0;
   resp_t        rq[$];
   wr_t          wq[$];
   resp_t        e_m;
   wr_t          w_m;
   logic [127:0] exp_ic, exp_dc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: a recognisable line per address, all-A's at 0x00010.
   function automatic logic [127:0] ram_f(input logic [19:0] a);
      if (a == 20'h00010) return {32{4'hA}};
      return {4{12'h5C3, a}};
   endfunction

   assign mem_rdata  = ram_f(mem_rd_addr);
   assign mem_rdata1 = ram_f(mem_rd_addr1);

   mem_arbiter #(.MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_data(ic_data),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_ready(dc_ready), .dc_data(dc_data),
      .mem_rd_addr(mem_rd_addr), .mem_rdata(mem_rdata), .mem_wr_addr(mem_wr_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we)
   );

   mem_arbiter #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_ready(ic_ready1), .ic_data(ic_data1),
      .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
      .dc_ready(dc_ready1), .dc_data(dc_data1),
      .mem_rd_addr(mem_rd_addr1), .mem_rdata(mem_rdata1), .mem_wr_addr(mem_wr_addr1),
      .mem_wdata(mem_wdata1), .mem_we(mem_we1)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_resp(input logic src, input logic [127:0] data);
      resp_t r;
      r.src  = src;
      r.data = data;
      rq.push_back(r);
   endtask

   task automatic push_wr(input logic [19:0] addr, input logic [127:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      wq.push_back(w);
   endtask

   task automatic check_outputs_zero(input string pre);
      check({pre, "_ic_ready"},    128'(ic_ready),    128'(0));
      check({pre, "_dc_ready"},    128'(dc_ready),    128'(0));
      check({pre, "_mem_we"},      128'(mem_we),      128'(0));
      check({pre, "_ic_data"},     ic_data,           128'(0));
      check({pre, "_dc_data"},     dc_data,           128'(0));
      check({pre, "_mem_rd_addr"}, 128'(mem_rd_addr), 128'(0));
      check({pre, "_mem_wr_addr"}, 128'(mem_wr_addr), 128'(0));
      check({pre, "_mem_wdata"},   mem_wdata,         128'(0));
   endtask

   // Bounded wait for a ready pulse on the latency-5 instance.
   task automatic wait_pulse(input logic use_dc, input int maxc, input string tag, output int at);
      logic seen;
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         if ((use_dc ? dc_ready : ic_ready) === 1'b1) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) check({tag, "_timeout"}, 128'(seen), 128'(1));
   endtask

   // Scoreboard: every ready pulse and every write strobe must match the queued expectation.
   always @(negedge clk) begin
      if (ic_ready === 1'b1 || dc_ready === 1'b1) begin
         check("ready_exclusive", 128'(ic_ready & dc_ready), 128'(0));
         check("ready_expected", 128'(rq.size() != 0), 128'(1));
         if (rq.size() != 0) begin
            e_m = rq.pop_front();
            check("ready_src", 128'(dc_ready), 128'(e_m.src));
            check("ready_data", e_m.src ? dc_data : ic_data, e_m.data);
         end
      end
      if (mem_we === 1'b1) begin
         we_cnt++;
         check("we_expected", 128'(wq.size() != 0), 128'(1));
         if (wq.size() != 0) begin
            w_m = wq.pop_front();
            check("we_addr", 128'(mem_wr_addr), 128'(w_m.addr));
            check("we_data", mem_wdata, w_m.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, tr, tprev, we0, dd;
      logic exp_b;
      reset = 1'b0;
      ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
      ic_req1 = 1'b0; ic_addr1 = '0; dc_req1 = 1'b0; dc_we1 = 1'b0; dc_addr1 = '0; dc_wdata1 = '0;
      exp_ic = '0;
      exp_dc = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      check("reset_mem_we1", 128'(mem_we1), 128'(0));
      reset = 1'b1;
      @(posedge clk); #1;

      // Single IC read
      exp_ic = ram_f(20'h00010);
      push_resp(1'b0, exp_ic);
      ic_addr = 20'h00010; ic_req = 1'b1; t0 = cyc; we0 = we_cnt;
      wait_pulse(1'b0, 20, "ic_read", tr);
      check("ic_read_latency", 128'(tr - t0), 128'(LAT + 1));
      @(posedge clk); #1;
      check("ic_read_pulse_width", 128'(ic_ready), 128'(0));
      check("ic_read_no_we", 128'(we_cnt - we0), 128'(0));
      ic_req = 1'b0;

      // DC write leaves dc_data alone
      push_wr(20'h00400, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_1234);
      push_resp(1'b1, exp_dc);
      dc_we = 1'b1; dc_addr = 20'h00400; dc_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_1234;
      dc_req = 1'b1; t0 = cyc; we0 = we_cnt;
      wait_pulse(1'b1, 20, "dc_write", tr);
      check("dc_write_latency", 128'(tr - t0), 128'(LAT + 1));
      @(posedge clk); #1;
      check("dc_write_pulse_width", 128'(dc_ready), 128'(0));
      check("dc_write_we_once", 128'(we_cnt - we0), 128'(1));
      check("dc_write_dc_data", dc_data, exp_dc);
      dc_req = 1'b0;

      // DC read
      exp_dc = ram_f(20'h00123);
      push_resp(1'b1, exp_dc);
      dc_we = 1'b0; dc_addr = 20'h00123; dc_req = 1'b1; we0 = we_cnt;
      wait_pulse(1'b1, 20, "dc_read", tr);
      @(posedge clk); #1;
      check("dc_read_no_we", 128'(we_cnt - we0), 128'(0));
      dc_req = 1'b0;

      // Requester changes mid-BUSY must not reach the RAM
      push_wr(20'h00200, {4{32'hCAFE_0001}});
      push_resp(1'b1, exp_dc);
      dc_we = 1'b1; dc_addr = 20'h00200; dc_wdata = {4{32'hCAFE_0001}}; dc_req = 1'b1;
      repeat (3) @(posedge clk); #1;
      dc_addr = 20'h003FF; dc_wdata = {4{32'hDEAD_0002}};
      #1;
      check("midbusy_rd_addr", 128'(mem_rd_addr), 128'(20'h00200));
      check("midbusy_wdata", mem_wdata, {4{32'hCAFE_0001}});
      wait_pulse(1'b1, 20, "midbusy", tr);
      @(posedge clk); #1;
      dc_req = 1'b0;
      check("dc_data_after_write", dc_data, exp_dc);

      // Contention from reset: IC first, then strict alternation
      reset = 1'b0;
      #1;
      exp_ic = '0;
      exp_dc = '0;
      check("reset2_dc_data", dc_data, 128'(0));
      check("queues_drained_before_tie", 128'(rq.size() + wq.size()), 128'(0));
      ic_addr = 20'h00050; dc_addr = 20'h00060; dc_we = 1'b0;
      ic_req = 1'b1; dc_req = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1; t0 = cyc;
      exp_ic = ram_f(20'h00050);
      exp_dc = ram_f(20'h00060);
      push_resp(1'b0, exp_ic); push_resp(1'b1, exp_dc);
      push_resp(1'b0, exp_ic); push_resp(1'b1, exp_dc);
      tprev = t0;
      for (int i = 0; i < 4; i++) begin
         wait_pulse(1'(i % 2), 20, "alternate", tr);
         check("alternate_spacing", 128'(tr - tprev), (i == 0) ? 128'(LAT + 1) : 128'(LAT + 2));
         tprev = tr;
      end
      @(posedge clk); #1;
      ic_req = 1'b0; dc_req = 1'b0;

      // Reset at cnt=2 of a DC write aborts it; the held request then completes
      dc_we = 1'b1; dc_addr = 20'h00480; dc_wdata = {8{16'hBEEF}}; dc_req = 1'b1;
      we0 = we_cnt;
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      #1;
      exp_ic = '0;
      exp_dc = '0;
      check_outputs_zero("abort");
      repeat (6) @(posedge clk); #1;
      check("abort_no_we", 128'(we_cnt - we0), 128'(0));
      push_wr(20'h00480, {8{16'hBEEF}});
      push_resp(1'b1, exp_dc);
      reset = 1'b1; t0 = cyc;
      wait_pulse(1'b1, 20, "after_abort", tr);
      check("after_abort_latency", 128'(tr - t0), 128'(LAT + 1));
      @(posedge clk); #1;
      dc_req = 1'b0;
      check("after_abort_we_once", 128'(we_cnt - we0), 128'(1));

      // Latency 1: held IC request is served every third cycle
      ic_addr1 = 20'h00077; ic_req1 = 1'b1; t0 = cyc;
      for (int d = 0; d < 13; d++) begin
         @(negedge clk);
         dd    = cyc - t0;
         exp_b = (dd >= 2) && (dd <= 8) && (((dd - 2) % 3) == 0);
         check("lat1_ic_ready", 128'(ic_ready1), 128'(exp_b));
         if (exp_b) check("lat1_ic_data", ic_data1, ram_f(20'h00077));
         if (dd == 9) ic_req1 = 1'b0;
      end

      // Latency 1: write strobe lands in the single BUSY cycle
      @(posedge clk); #1;
      dc_we1 = 1'b1; dc_addr1 = 20'h00ABC; dc_wdata1 = {2{64'h1111_2222_3333_4444}};
      dc_req1 = 1'b1; t0 = cyc;
      for (int d = 0; d < 5; d++) begin
         @(negedge clk);
         dd = cyc - t0;
         check("lat1_mem_we", 128'(mem_we1), 128'(dd == 1));
         if (dd == 1) begin
            check("lat1_wr_addr", 128'(mem_wr_addr1), 128'(20'h00ABC));
            check("lat1_wdata", mem_wdata1, {2{64'h1111_2222_3333_4444}});
         end
         check("lat1_dc_ready", 128'(dc_ready1), 128'(dd == 2));
         if (dd == 2) dc_req1 = 1'b0;
      end
      check("lat1_dc_data_held", dc_data1, 128'(0));

      repeat (3) @(posedge clk); #1;
      check("final_resp_queue", 128'(rq.size()), 128'(0));
      check("final_wr_queue", 128'(wq.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, default 5, gives the number of BUSY cycles per memory transaction; the legal range is 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset: 0 resets the block immediately, 1 lets it run.
REQ-004 ic_req  input  1  instruction-cache line-fill request, held until ic_ready.
REQ-005 ic_addr  input  20  instruction-cache line address, stable while ic_req=1.
REQ-006 ic_ready  output  1  one-cycle pulse marking ic_data valid.
REQ-007 ic_data  output  128  returned instruction line.
REQ-008 dc_req  input  1  data-cache request (read or write), held until dc_ready.
REQ-009 dc_we  input  1  1 = write line, 0 = read line; stable while dc_req=1.
REQ-010 dc_addr  input  20  data-cache line address.
REQ-011 dc_wdata  input  128  data-cache write line.
REQ-012 dc_ready  output  1  one-cycle completion pulse for a data-cache read or write.
REQ-013 dc_data  output  128  returned data line.
REQ-014 mem_rd_addr  output  20  read address to the RAM.
REQ-015 mem_rdata  input  128  RAM read line, combinational from mem_rd_addr.
REQ-016 mem_wr_addr  output  20  write address to the RAM.
REQ-017 mem_wdata  output  128  write line to the RAM.
REQ-018 mem_we  output  1  RAM write strobe.

Function
REQ-019 States: IDLE, BUSY, RESP; a 4-bit down-counter cnt and a 1-bit last_grant (0=IC, 1=DC).
REQ-020 In IDLE with exactly one request high, that requester is granted at the clock edge.
REQ-021 In IDLE with both requests high, the grant goes to the source not equal to last_grant; last_grant then updates to the granted source.
REQ-022 On grant: latch the source, address, we and wdata (we=0 for IC); set cnt=MEM_LATENCY-1; go to BUSY.
REQ-023 Requester inputs are ignored outside IDLE; later changes on req, addr or wdata do not alter the latched transaction.
REQ-024 In BUSY: mem_rd_addr and mem_wr_addr drive the latched address; mem_wdata drives the latched wdata; cnt decrements each cycle.
REQ-025 In BUSY with cnt=0: mem_we=latched we for exactly that one cycle.
REQ-026 In BUSY with cnt=0, for a read: mem_rdata is captured into the source's data register.
REQ-027 In BUSY with cnt=0: go to RESP.
REQ-028 mem_we is 0 in every other state and cycle; each write transaction produces exactly one mem_we cycle.
REQ-029 In RESP: the latched source's ready output is 1 for exactly one cycle; the other ready output is 0; next state is IDLE.
REQ-030 Latency: a request sampled at edge E gets ready high in the cycle after edge E+MEM_LATENCY, i.e. the response arrives MEM_LATENCY+1 cycles after grant.
REQ-031 Throughput: at most one transaction per MEM_LATENCY+2 cycles, because IDLE always lasts at least one cycle.
REQ-032 ic_data and dc_data are registers that change only on a read capture and otherwise hold their value; a DC write leaves dc_data unchanged.
REQ-033 A request still high in the IDLE cycle after its ready pulse is a new request and is arbitrated normally.
REQ-034 Addresses pass to the RAM unmodified; the block performs no shifting or alignment.
REQ-035 In IDLE, mem_rd_addr and mem_wr_addr hold their last value.

Reset
REQ-036 reset=0 forces, asynchronously: state=IDLE, cnt=0, last_grant=1 (IC wins the first tie), ic_ready=0, dc_ready=0, mem_we=0, all address, data and wdata outputs 0.
REQ-037 Reset during BUSY or RESP discards the transaction; no ready pulse follows, and mem_we falls in the same cycle reset asserts.
REQ-038 Requests still high when reset deasserts are arbitrated at the first clock edge that sees reset=1.

Verification
REQ-039 Single IC read, MEM_LATENCY=5, ic_addr=0x00010, RAM returning 0xAAAA...: ic_ready pulses once, 6 cycles after grant, ic_data=that line, mem_we stays 0.
REQ-040 DC write, dc_addr=0x00400, dc_wdata=0x...1234: mem_we high exactly one cycle with mem_wr_addr=0x00400 and mem_wdata=0x...1234; dc_ready pulses once; dc_data unchanged.
REQ-041 IC and DC asserted together from reset, both held: IC served first, then DC, then IC; grants alternate and neither requester starves.
REQ-042 Change dc_addr and dc_wdata mid-BUSY: the RAM still sees the originally latched values.
REQ-043 Assert reset (reset=0) on BUSY cnt=2 of a DC write: mem_we never asserts, no dc_ready, all outputs 0; after release a held request completes normally.
REQ-044 MEM_LATENCY=1 with back-to-back IC requests: ready every 3 cycles and each ready pulse is one cycle wide.
